// File: rtl/grid_draw_control.sv
// grid_draw_control
//   Control FSM for the Life-grid cell painter. It sweeps every cell of the
//   grid row by row and fetches one row word per row from board memory. For
//   each cell it issues the ld_x/ld_y/ld_c/enable strobes so the datapath
//   paints the cell as a 4x4 VGA block. It also drives the VGA plot strobe.
//
//   Parameters
//     COLS : cells per row (<= 64); width of row_data/data
//     ROWS : grid rows (<= 32)
//
//   Ports
//     clk       in   clock, rising edge
//     reset_n   in   asynchronous active-low reset
//     start     in   begin one full-frame redraw (sampled in IDLE only)
//     row_rd    out  1-cycle read strobe for row row_sel
//     row_data  in   row word, valid the cycle after row_rd
//     row_sel   out  current row (memory address / datapath y register)
//     addr      out  current column (datapath addr)
//     data      out  latched row word (datapath data)
//     ld_x/ld_y/ld_c out  datapath x/y/colour loads
//     enable    out  datapath pixel-counter enable
//     plot      out  VGA write enable
//     busy      out  high in every state except IDLE
//     done      out  1-cycle pulse at end of frame
//
//   All outputs are registered. Each strobe is set on the transition into
//   the state that owns it, so it is high exactly for that state's cycles.
module grid_draw_control #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            row_rd,
  input  logic [COLS-1:0] row_data,
  output logic [4:0]      row_sel,
  output logic [5:0]      addr,
  output logic [COLS-1:0] data,
  output logic            ld_x,
  output logic            ld_y,
  output logic            ld_c,
  output logic            enable,
  output logic            plot,
  output logic            busy,
  output logic            done
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] LAST_CNT = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_LOAD,
    S_DRAW,
    S_DONE
  } state_t;

  state_t     state;
  logic [4:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      row_sel <= '0;
      addr    <= '0;
      data    <= '0;
      row_rd  <= 1'b0;
      ld_x    <= 1'b0;
      ld_y    <= 1'b0;
      ld_c    <= 1'b0;
      enable  <= 1'b0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // Single-cycle strobes default low; the transition below raises the
      // ones belonging to the state being entered.
      row_rd <= 1'b0;
      ld_x   <= 1'b0;
      ld_y   <= 1'b0;
      ld_c   <= 1'b0;
      enable <= 1'b0;
      plot   <= 1'b0;
      done   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            row_sel <= '0;
            addr    <= '0;
            row_rd  <= 1'b1;
            busy    <= 1'b1;
          end
        end

        S_FETCH: begin
          state <= S_LATCH;
        end

        S_LATCH: begin
          // Memory presents the row word during this cycle; it is held for
          // every cell of the row.
          data  <= row_data;
          state <= S_LOAD;
          ld_x  <= 1'b1;
          ld_y  <= 1'b1;
          ld_c  <= 1'b1;
        end

        S_LOAD: begin
          // First DRAW cycle: datapath counter still reads 0 (it was held
          // during LOAD), which repeats offset 0, so plot stays low.
          state  <= S_DRAW;
          cnt    <= '0;
          enable <= 1'b1;
        end

        S_DRAW: begin
          if (cnt == LAST_CNT) begin
            if (addr != LAST_COL) begin
              addr  <= addr + 6'd1;
              state <= S_LOAD;
              ld_x  <= 1'b1;
              ld_y  <= 1'b1;
              ld_c  <= 1'b1;
            end else if (row_sel != LAST_ROW) begin
              addr    <= '0;
              row_sel <= row_sel + 5'd1;
              state   <= S_FETCH;
              row_rd  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            cnt    <= cnt + 5'd1;
            enable <= 1'b1;
            plot   <= 1'b1;
          end
        end

        S_DONE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          row_sel <= '0;
          addr    <= '0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
